softmax_rowmax_sub: RTL and testbench
=====================================

Name: softmax_rowmax_sub

Overview:
- Sits directly upstream of the softmax stage.
- Receives the int32 attention-score matrix (N x N, row-major) from the QK^T matmul as an AXI-stream.
- Buffers each row, finds the row maximum, then streams q - max(row) with saturation. Every output is therefore <= 0, which is the input range the integer exp polynomial expects.
- Ping-pong row buffer: one row fills while the previous row drains, giving 1 element/cycle sustained.

Parameters:
- D_W_ACC, 32: data width of qin/qout (signed).
- MATRIXSIZE_W, 16: width of row/column counters.
- N, 32: row length and row count per matrix (N >= 1).

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- qin.tdata  input  D_W_ACC  signed score element.
- qin.tvalid  input  1  element valid.
- qin.tready  output  1  block accepts element.
- qin.tlast  input  1  upstream end-of-matrix; used only for the error check.
- qout.tdata  output  D_W_ACC  signed, saturated (q - rowmax).
- qout.tvalid  output  1  output valid.
- qout.tready  input  1  downstream accepts.
- qout.tlast  output  1  high on element (row N-1, col N-1) of each output matrix.
- frame_err  output  1  sticky: qin.tlast did not coincide with input element (N-1, N-1).

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - Both banks EMPTY; write/read counters = 0; bank selectors = bank 0.
  - qout.tvalid=0, qout.tdata=0, qout.tlast=0, frame_err=0.
  - Buffered data is discarded, including when rst is asserted mid-row.
- Storage: two banks of N x D_W_ACC words, each with a max register. Bank states: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
- Write side:
  - Transfer occurs when qin.tvalid & qin.tready.
  - qin.tready = 1 iff the current write bank is EMPTY or FILLING.
  - Element at wcol is stored at address wcol. Max register loads the element when wcol == 0; otherwise max <= signed max(max, element).
  - At wcol == N-1: bank -> FULL at that edge, write selector toggles, wcol wraps to 0, wrow increments (wraps at N-1 -> 0).
  - frame_err sets on any accepted element whose qin.tlast != (wrow==N-1 && wcol==N-1). Cleared only by rst.
- Read side:
  - One registered output stage.
  - A read is issued when the read bank is FULL or DRAINING AND (qout.tvalid==0 OR qout.tready==1).
  - A read loads qout.tdata <= sat(mem[rcol] - max) and sets qout.tvalid=1.
  - qout.tlast is loaded as (rrow==N-1 && rcol==N-1).
  - When no read is issued and a handshake completes, qout.tvalid -> 0.
  - While qout.tvalid=1 and qout.tready=0, tdata/tlast hold stable.
  - Read issued at rcol == N-1: bank -> EMPTY at that edge and becomes writable from the next cycle (no same-cycle bypass). Read selector toggles, rcol wraps, rrow advances (wraps at N-1 -> 0).
- Arithmetic:
  - Subtraction is done in D_W_ACC+1 bits, then saturated to [-2^(D_W_ACC-1), 2^(D_W_ACC-1)-1].
  - Because max >= element, only negative saturation occurs in practice.
- Latency and throughput:
  - Last element of a row accepted at edge k -> bank FULL at k -> first read at edge k+1 -> qout.tvalid high after edge k+1.
  - With qin.tvalid=1 and qout.tready=1 held, qin.tready stays 1 continuously from reset. Output is one element/cycle after the first N+1 cycles.
- Boundaries:
  - Both banks FULL -> qin.tready=0 until a bank drains.
  - Simultaneous write-complete and read-complete in the same cycle on different banks are both honoured.
  - N=1: every output is 0 and tlast is high on every output.

Test Plan:
- N=4, row [3,-7,10,2], both sides always ready -> qout [-7,-17,0,-8]; qout.tvalid rises one cycle after the 4th input is accepted.
- N=4, full 4x4 matrix streamed back-to-back with qout.tready=1 -> qin.tready never drops. 16 outputs with one qout.tlast, on the 16th. frame_err=0 when qin.tlast is given on the 16th input.
- Row [-2^31, 2^31-1, 0, 0] -> outputs [-2^31 (saturated), 0, -(2^31-1), -(2^31-1)].
- qout.tready=0 for 12 cycles while streaming -> qin.tready drops after 8 inputs (both banks FULL). qout.tdata stays stable at the row-0 col-0 value. Releasing tready produces the full correct sequence with no loss or duplication.
- rst pulsed after 2 inputs of row 1 -> qout.tvalid=0 next cycle. A new row [1,1,1,1] then yields [0,0,0,0] with row counters restarted (tlast on the 16th post-reset output).
- qin.tlast asserted on input 5 of a 4x4 matrix -> frame_err=1 and stays 1 until rst; data path is unaffected.

Source files
------------

// File: rtl/softmax_rowmax_sub.sv
// Row-max subtraction ahead of softmax: buffers each score row in a ping-pong
// bank pair and streams saturated (q - rowmax) values, so every output is <= 0.
module softmax_rowmax_sub #(
    parameter int D_W_ACC      = 32,
    parameter int MATRIXSIZE_W = 16,
    parameter int N            = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [D_W_ACC-1:0] qin_tdata,
    input  logic                      qin_tvalid,
    output logic                      qin_tready,
    input  logic                      qin_tlast,
    output logic signed [D_W_ACC-1:0] qout_tdata,
    output logic                      qout_tvalid,
    input  logic                      qout_tready,
    output logic                      qout_tlast,
    output logic                      frame_err
);

    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam logic [MATRIXSIZE_W-1:0] LAST_IDX = MATRIXSIZE_W'(N - 1);

    typedef enum logic [1:0] {
        B_EMPTY    = 2'd0,
        B_FILLING  = 2'd1,
        B_FULL     = 2'd2,
        B_DRAINING = 2'd3
    } bank_state_e;

    bank_state_e                bank_q [2];
    bank_state_e                bank_d [2];
    logic signed [D_W_ACC-1:0]  max_q  [2];
    logic signed [D_W_ACC-1:0]  max_d  [2];
    logic signed [D_W_ACC-1:0]  mem    [2][N];

    logic                       wsel_q, wsel_d, rsel_q, rsel_d;
    logic [MATRIXSIZE_W-1:0]    wcol_q, wcol_d, wrow_q, wrow_d;
    logic [MATRIXSIZE_W-1:0]    rcol_q, rcol_d, rrow_q, rrow_d;
    logic signed [D_W_ACC-1:0]  qout_tdata_q, qout_tdata_d;
    logic                       qout_tvalid_q, qout_tvalid_d;
    logic                       qout_tlast_q, qout_tlast_d;
    logic                       frame_err_q, frame_err_d;

    logic                       wr_fire_s, rd_fire_s, rd_avail_s;
    logic signed [D_W_ACC-1:0]  rd_elem_s;

    // Subtract in one extra bit, then clamp to the signed D_W_ACC range.
    function automatic logic signed [D_W_ACC-1:0] sat_sub(
        input logic signed [D_W_ACC-1:0] a,
        input logic signed [D_W_ACC-1:0] b
    );
        logic signed [D_W_ACC:0] diff;
        logic signed [D_W_ACC-1:0] res;
        diff = {a[D_W_ACC-1], a} - {b[D_W_ACC-1], b};
        if (diff[D_W_ACC] != diff[D_W_ACC-1]) begin
            res = diff[D_W_ACC] ? {1'b1, {(D_W_ACC-1){1'b0}}}
                                : {1'b0, {(D_W_ACC-1){1'b1}}};
        end else begin
            res = diff[D_W_ACC-1:0];
        end
        return res;
    endfunction

    assign qout_tdata  = qout_tdata_q;
    assign qout_tvalid = qout_tvalid_q;
    assign qout_tlast  = qout_tlast_q;
    assign frame_err   = frame_err_q;

    // Handshake qualifiers and the combinational read of the drain bank.
    always_comb begin
        qin_tready = (bank_q[wsel_q] == B_EMPTY) || (bank_q[wsel_q] == B_FILLING);
        rd_avail_s = (bank_q[rsel_q] == B_FULL) || (bank_q[rsel_q] == B_DRAINING);
        wr_fire_s  = qin_tvalid && qin_tready;
        rd_fire_s  = rd_avail_s && (!qout_tvalid_q || qout_tready);
        rd_elem_s  = mem[rsel_q][rcol_q[AW-1:0]];
    end

    // Next-state for both bank pointers, max registers and the output stage.
    // Write and read always target different banks, so their updates never collide.
    always_comb begin
        bank_d        = bank_q;
        max_d         = max_q;
        wsel_d        = wsel_q;
        rsel_d        = rsel_q;
        wcol_d        = wcol_q;
        wrow_d        = wrow_q;
        rcol_d        = rcol_q;
        rrow_d        = rrow_q;
        qout_tdata_d  = qout_tdata_q;
        qout_tvalid_d = qout_tvalid_q;
        qout_tlast_d  = qout_tlast_q;
        frame_err_d   = frame_err_q;

        if (wr_fire_s) begin
            if (wcol_q == '0) begin
                max_d[wsel_q] = qin_tdata;
            end else if (qin_tdata > max_q[wsel_q]) begin
                max_d[wsel_q] = qin_tdata;
            end else begin
                max_d[wsel_q] = max_q[wsel_q];
            end
            if (qin_tlast != ((wrow_q == LAST_IDX) && (wcol_q == LAST_IDX))) begin
                frame_err_d = 1'b1;
            end else begin
                frame_err_d = frame_err_q;
            end
            if (wcol_q == LAST_IDX) begin
                bank_d[wsel_q] = B_FULL;
                wsel_d         = ~wsel_q;
                wcol_d         = '0;
                wrow_d         = (wrow_q == LAST_IDX) ? '0 : wrow_q + MATRIXSIZE_W'(1);
            end else begin
                bank_d[wsel_q] = B_FILLING;
                wcol_d         = wcol_q + MATRIXSIZE_W'(1);
            end
        end else begin
            wcol_d = wcol_q;
        end

        if (rd_fire_s) begin
            qout_tdata_d  = sat_sub(rd_elem_s, max_q[rsel_q]);
            qout_tvalid_d = 1'b1;
            qout_tlast_d  = (rrow_q == LAST_IDX) && (rcol_q == LAST_IDX);
            if (rcol_q == LAST_IDX) begin
                bank_d[rsel_q] = B_EMPTY;
                rsel_d         = ~rsel_q;
                rcol_d         = '0;
                rrow_d         = (rrow_q == LAST_IDX) ? '0 : rrow_q + MATRIXSIZE_W'(1);
            end else begin
                bank_d[rsel_q] = B_DRAINING;
                rcol_d         = rcol_q + MATRIXSIZE_W'(1);
            end
        end else if (qout_tready) begin
            qout_tvalid_d = 1'b0;
        end else begin
            qout_tvalid_d = qout_tvalid_q;
        end
    end

    // Row storage; contents need no reset since bank state gates every read.
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            mem[wsel_q][wcol_q[AW-1:0]] <= qin_tdata;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                bank_q[b] <= B_EMPTY;
                max_q[b]  <= '0;
            end
            wsel_q        <= 1'b0;
            rsel_q        <= 1'b0;
            wcol_q        <= '0;
            wrow_q        <= '0;
            rcol_q        <= '0;
            rrow_q        <= '0;
            qout_tdata_q  <= '0;
            qout_tvalid_q <= 1'b0;
            qout_tlast_q  <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                bank_q[b] <= bank_d[b];
                max_q[b]  <= max_d[b];
            end
            wsel_q        <= wsel_d;
            rsel_q        <= rsel_d;
            wcol_q        <= wcol_d;
            wrow_q        <= wrow_d;
            rcol_q        <= rcol_d;
            rrow_q        <= rrow_d;
            qout_tdata_q  <= qout_tdata_d;
            qout_tvalid_q <= qout_tvalid_d;
            qout_tlast_q  <= qout_tlast_d;
            frame_err_q   <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_softmax_rowmax_sub.sv
// Directed bench for softmax_rowmax_sub with N=4: one task per scenario,
// expected outputs hand-computed from the row-max subtraction rule.
module tb_softmax_rowmax_sub;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [31:0] qin_tdata = 32'sd0;
    logic               qin_tvalid = 1'b0;
    logic               qin_tready;
    logic               qin_tlast = 1'b0;
    logic signed [31:0] qout_tdata;
    logic               qout_tvalid;
    logic               qout_tready = 1'b1;
    logic               qout_tlast;
    logic               frame_err;

    int n_pass  = 0;
    int n_total = 0;

    logic signed [31:0] out_q [$];
    logic               last_q [$];
    int                 acc_cnt   = 0;
    int                 stall_cnt = 0;

    logic signed [31:0] b2b_in  [16] = '{32'sd1, 32'sd2, 32'sd3, 32'sd4,
                                         -32'sd5, -32'sd5, -32'sd5, -32'sd5,
                                         32'sd100, -32'sd100, 32'sd50, 32'sd0,
                                         32'sd7, 32'sd8, -32'sd9, 32'sd8};
    logic signed [31:0] b2b_exp [16] = '{-32'sd3, -32'sd2, -32'sd1, 32'sd0,
                                         32'sd0, 32'sd0, 32'sd0, 32'sd0,
                                         32'sd0, -32'sd200, -32'sd50, -32'sd100,
                                         -32'sd1, 32'sd0, -32'sd17, 32'sd0};
    logic signed [31:0] bp_in   [12] = '{32'sd2, 32'sd5, -32'sd3, 32'sd1,
                                         32'sd0, 32'sd0, -32'sd1, 32'sd2,
                                         -32'sd10, -32'sd20, -32'sd30, -32'sd40};
    logic signed [31:0] bp_exp  [12] = '{-32'sd3, 32'sd0, -32'sd8, -32'sd4,
                                         -32'sd2, -32'sd2, -32'sd3, 32'sd0,
                                         32'sd0, -32'sd10, -32'sd20, -32'sd30};

    softmax_rowmax_sub #(
        .D_W_ACC      (32),
        .MATRIXSIZE_W (16),
        .N            (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .qin_tdata   (qin_tdata),
        .qin_tvalid  (qin_tvalid),
        .qin_tready  (qin_tready),
        .qin_tlast   (qin_tlast),
        .qout_tdata  (qout_tdata),
        .qout_tvalid (qout_tvalid),
        .qout_tready (qout_tready),
        .qout_tlast  (qout_tlast),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    // Record transfers that will complete at the following rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (qout_tvalid && qout_tready) begin
                out_q.push_back(qout_tdata);
                last_q.push_back(qout_tlast);
            end
            if (qin_tvalid && qin_tready) acc_cnt = acc_cnt + 1;
            if (qin_tvalid && !qin_tready) stall_cnt = stall_cnt + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic do_reset();
        rst = 1'b1;
        qin_tvalid = 1'b0;
        qin_tlast = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic push(input logic signed [31:0] v, input logic l);
        int w;
        w = 0;
        qin_tdata = v;
        qin_tlast = l;
        qin_tvalid = 1'b1;
        @(negedge clk);
        while (!qin_tready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!qin_tready) begin
            n_total++;
            $display("FAIL push_timeout value %0d never accepted", v);
        end
        @(posedge clk);
        #1;
        qin_tvalid = 1'b0;
        qin_tlast = 1'b0;
    endtask

    task automatic wait_out(input int target);
        int w;
        w = 0;
        while (out_q.size() < target && w < 200) begin
            @(posedge clk);
            w++;
        end
        #1;
        if (out_q.size() < target) begin
            n_total++;
            $display("FAIL out_timeout got %0d outputs want %0d", out_q.size(), target);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (qout_tvalid !== 1'b0) $display("FAIL rst_tvalid got %b want 0", qout_tvalid); else n_pass++;
        n_total++; if (qout_tdata !== 32'sd0) $display("FAIL rst_tdata got %0d want 0", qout_tdata); else n_pass++;
        n_total++; if (qout_tlast !== 1'b0) $display("FAIL rst_tlast got %b want 0", qout_tlast); else n_pass++;
        n_total++; if (frame_err !== 1'b0) $display("FAIL rst_frame_err got %b want 0", frame_err); else n_pass++;
        n_total++; if (qin_tready !== 1'b1) $display("FAIL rst_qin_tready got %b want 1", qin_tready); else n_pass++;
    endtask

    task automatic test_single_row();
        logic signed [31:0] rin [4];
        logic signed [31:0] rexp [4];
        logic signed [31:0] od;
        int base;
        rin  = '{32'sd3, -32'sd7, 32'sd10, 32'sd2};
        rexp = '{-32'sd7, -32'sd17, 32'sd0, -32'sd8};
        do_reset();
        qout_tready = 1'b1;
        base = out_q.size();
        for (int i = 0; i < 4; i++) push(rin[i], 1'b0);
        n_total++; if (qout_tvalid !== 1'b0) $display("FAIL row_tvalid_early got %b want 0", qout_tvalid); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (qout_tvalid !== 1'b1) $display("FAIL row_tvalid_rise got %b want 1", qout_tvalid); else n_pass++;
        wait_out(base + 4);
        for (int i = 0; i < 4; i++) begin
            od = (base + i < out_q.size()) ? out_q[base + i] : 32'hxxxx_xxxx;
            n_total++;
            if (od !== rexp[i]) $display("FAIL row_data[%0d] got %0d want %0d", i, od, rexp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic signed [31:0] od;
        logic ol;
        int base, stall0;
        do_reset();
        qout_tready = 1'b1;
        base = out_q.size();
        stall0 = stall_cnt;
        for (int i = 0; i < 16; i++) push(b2b_in[i], (i == 15) ? 1'b1 : 1'b0);
        wait_out(base + 16);
        n_total++; if (stall_cnt - stall0 != 0) $display("FAIL b2b_stalls got %0d want 0", stall_cnt - stall0); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            od = (base + i < out_q.size()) ? out_q[base + i] : 32'hxxxx_xxxx;
            ol = (base + i < last_q.size()) ? last_q[base + i] : 1'bx;
            n_total++;
            if (od !== b2b_exp[i]) $display("FAIL b2b_data[%0d] got %0d want %0d", i, od, b2b_exp[i]);
            else n_pass++;
            n_total++;
            if (ol !== ((i == 15) ? 1'b1 : 1'b0)) $display("FAIL b2b_tlast[%0d] got %b want %b", i, ol, (i == 15));
            else n_pass++;
        end
        n_total++; if (frame_err !== 1'b0) $display("FAIL b2b_frame_err got %b want 0", frame_err); else n_pass++;
    endtask

    task automatic test_saturation();
        logic signed [31:0] rin [4];
        logic signed [31:0] rexp [4];
        logic signed [31:0] od;
        int base;
        rin  = '{32'sh8000_0000, 32'sh7FFF_FFFF, 32'sd0, 32'sd0};
        rexp = '{32'sh8000_0000, 32'sd0, 32'sh8000_0001, 32'sh8000_0001};
        do_reset();
        qout_tready = 1'b1;
        base = out_q.size();
        for (int i = 0; i < 4; i++) push(rin[i], 1'b0);
        wait_out(base + 4);
        for (int i = 0; i < 4; i++) begin
            od = (base + i < out_q.size()) ? out_q[base + i] : 32'hxxxx_xxxx;
            n_total++;
            if (od !== rexp[i]) $display("FAIL sat_data[%0d] got %0d want %0d", i, od, rexp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic signed [31:0] od;
        int base, acc0;
        do_reset();
        qout_tready = 1'b0;
        base = out_q.size();
        acc0 = acc_cnt;
        fork
            begin
                for (int i = 0; i < 12; i++) push(bp_in[i], 1'b0);
            end
            begin
                repeat (12) @(posedge clk);
                #1;
                n_total++; if (acc_cnt - acc0 != 8) $display("FAIL bp_accepted got %0d want 8", acc_cnt - acc0); else n_pass++;
                n_total++; if (qin_tready !== 1'b0) $display("FAIL bp_qin_tready got %b want 0", qin_tready); else n_pass++;
                n_total++; if (qout_tvalid !== 1'b1) $display("FAIL bp_tvalid got %b want 1", qout_tvalid); else n_pass++;
                n_total++; if (qout_tdata !== -32'sd3) $display("FAIL bp_hold_data got %0d want -3", qout_tdata); else n_pass++;
                qout_tready = 1'b1;
            end
        join
        wait_out(base + 12);
        n_total++; if (out_q.size() - base != 12) $display("FAIL bp_count got %0d want 12", out_q.size() - base); else n_pass++;
        for (int i = 0; i < 12; i++) begin
            od = (base + i < out_q.size()) ? out_q[base + i] : 32'hxxxx_xxxx;
            n_total++;
            if (od !== bp_exp[i]) $display("FAIL bp_data[%0d] got %0d want %0d", i, od, bp_exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        logic signed [31:0] od;
        logic ol;
        int base;
        do_reset();
        qout_tready = 1'b1;
        for (int i = 0; i < 4; i++) push(32'sd9, 1'b0);
        push(32'sd3, 1'b0);
        push(32'sd3, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        n_total++; if (qout_tvalid !== 1'b0) $display("FAIL mrst_tvalid got %b want 0", qout_tvalid); else n_pass++;
        base = out_q.size();
        for (int i = 0; i < 16; i++) push(32'sd1, (i == 15) ? 1'b1 : 1'b0);
        wait_out(base + 16);
        for (int i = 0; i < 16; i++) begin
            od = (base + i < out_q.size()) ? out_q[base + i] : 32'hxxxx_xxxx;
            ol = (base + i < last_q.size()) ? last_q[base + i] : 1'bx;
            n_total++;
            if (od !== 32'sd0) $display("FAIL mrst_data[%0d] got %0d want 0", i, od);
            else n_pass++;
            n_total++;
            if (ol !== ((i == 15) ? 1'b1 : 1'b0)) $display("FAIL mrst_tlast[%0d] got %b want %b", i, ol, (i == 15));
            else n_pass++;
        end
        n_total++; if (frame_err !== 1'b0) $display("FAIL mrst_frame_err got %b want 0", frame_err); else n_pass++;
    endtask

    task automatic test_frame_err();
        logic signed [31:0] od;
        int base;
        do_reset();
        qout_tready = 1'b1;
        base = out_q.size();
        for (int i = 0; i < 4; i++) push(b2b_in[i], 1'b0);
        n_total++; if (frame_err !== 1'b0) $display("FAIL ferr_before got %b want 0", frame_err); else n_pass++;
        push(b2b_in[4], 1'b1);
        n_total++; if (frame_err !== 1'b1) $display("FAIL ferr_set got %b want 1", frame_err); else n_pass++;
        for (int i = 5; i < 16; i++) push(b2b_in[i], 1'b0);
        wait_out(base + 16);
        n_total++; if (frame_err !== 1'b1) $display("FAIL ferr_sticky got %b want 1", frame_err); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            od = (base + i < out_q.size()) ? out_q[base + i] : 32'hxxxx_xxxx;
            n_total++;
            if (od !== b2b_exp[i]) $display("FAIL ferr_data[%0d] got %0d want %0d", i, od, b2b_exp[i]);
            else n_pass++;
        end
        do_reset();
        n_total++; if (frame_err !== 1'b0) $display("FAIL ferr_cleared got %b want 0", frame_err); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_row();
        test_back_to_back();
        test_saturation();
        test_backpressure();
        test_mid_reset();
        test_frame_err();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
